// File: rtl/door_sensor_decoder.sv
// Two-beam doorway decoder: synchronizes and debounces the beam sensors, then
// tracks entry/exit sequences and emits single-cycle up/down/fault pulses.
module door_sensor_decoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned TIMEOUT_CYCLES  = 200000000
) (
    input  logic clk,
    input  logic rst,
    input  logic sens_a,
    input  logic sens_b,
    output logic up,
    output logic down,
    output logic fault,
    output logic busy
);
    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned DW_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW_W-1:0] DW_LAST = DW_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENT1,
        S_ENT2,
        S_ENT3,
        S_EXT1,
        S_EXT2,
        S_EXT3,
        S_WAIT_CLR
    } state_t;

    // Channel vectors are {A, B}, so filt_q is directly the (A,B) pattern.
    logic [1:0]      meta_q, meta_d;
    logic [1:0]      sync_q, sync_d;
    logic [1:0]      filt_q, filt_d;
    logic [DB_W-1:0] cnt_q [2];
    logic [DB_W-1:0] cnt_d [2];
    logic [DW_W-1:0] dwell_q, dwell_d;
    state_t          state_q, state_d;
    logic            up_q, up_d;
    logic            down_q, down_d;
    logic            fault_q, fault_d;
    logic            busy_q, busy_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q  <= '0;
            sync_q  <= '0;
            filt_q  <= '0;
            cnt_q   <= '{default: '0};
            dwell_q <= '0;
            state_q <= S_IDLE;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            fault_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            meta_q  <= meta_d;
            sync_q  <= sync_d;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            state_q <= state_d;
            up_q    <= up_d;
            down_q  <= down_d;
            fault_q <= fault_d;
            busy_q  <= busy_d;
        end
    end

    // Synchronizer and per-channel debounce: toggle after DEBOUNCE_CYCLES disagreeing samples.
    always_comb begin
        meta_d   = {sens_a, sens_b};
        sync_d   = meta_q;
        filt_d   = filt_q;
        cnt_d[0] = '0;
        cnt_d[1] = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync_q[i] != filt_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    filt_d[i] = ~filt_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    // Sequence tracker; the timeout override takes priority over any pattern move.
    always_comb begin
        state_d = state_q;
        up_d    = 1'b0;
        down_d  = 1'b0;
        fault_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                case (filt_q)
                    2'b10:   state_d = S_ENT1;
                    2'b01:   state_d = S_EXT1;
                    2'b11:   begin state_d = S_WAIT_CLR; fault_d = 1'b1; end
                    default: ;
                endcase
            end
            S_ENT1: begin
                case (filt_q)
                    2'b11:   state_d = S_ENT2;
                    2'b00:   state_d = S_IDLE;
                    2'b01:   begin state_d = S_WAIT_CLR; fault_d = 1'b1; end
                    default: ;
                endcase
            end
            S_ENT2: begin
                case (filt_q)
                    2'b01:   state_d = S_ENT3;
                    2'b10:   state_d = S_ENT1;
                    2'b00:   begin state_d = S_WAIT_CLR; fault_d = 1'b1; end
                    default: ;
                endcase
            end
            S_ENT3: begin
                case (filt_q)
                    2'b00:   begin state_d = S_IDLE; up_d = 1'b1; end
                    2'b11:   state_d = S_ENT2;
                    2'b10:   begin state_d = S_WAIT_CLR; fault_d = 1'b1; end
                    default: ;
                endcase
            end
            S_EXT1: begin
                case (filt_q)
                    2'b11:   state_d = S_EXT2;
                    2'b00:   state_d = S_IDLE;
                    2'b10:   begin state_d = S_WAIT_CLR; fault_d = 1'b1; end
                    default: ;
                endcase
            end
            S_EXT2: begin
                case (filt_q)
                    2'b10:   state_d = S_EXT3;
                    2'b01:   state_d = S_EXT1;
                    2'b00:   begin state_d = S_WAIT_CLR; fault_d = 1'b1; end
                    default: ;
                endcase
            end
            S_EXT3: begin
                case (filt_q)
                    2'b00:   begin state_d = S_IDLE; down_d = 1'b1; end
                    2'b11:   state_d = S_EXT2;
                    2'b01:   begin state_d = S_WAIT_CLR; fault_d = 1'b1; end
                    default: ;
                endcase
            end
            S_WAIT_CLR: begin
                if (filt_q == 2'b00) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q != S_IDLE && state_q != S_WAIT_CLR && dwell_q == DW_LAST) begin
            state_d = S_WAIT_CLR;
            up_d    = 1'b0;
            down_d  = 1'b0;
            fault_d = 1'b1;
        end

        if (state_d != state_q || state_d == S_IDLE || state_d == S_WAIT_CLR) begin
            dwell_d = '0;
        end else begin
            dwell_d = dwell_q + DW_W'(1);
        end
        busy_d = (state_d != S_IDLE);
    end

    assign up    = up_q;
    assign down  = down_q;
    assign fault = fault_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_door_sensor_decoder.sv
// Scoreboard bench: a sequence-level reference model predicts pulses and busy,
// a negedge monitor compares them against the DUT.
module tb_door_sensor_decoder;
    localparam int unsigned DB = 4;
    localparam int unsigned TO = 64;
    localparam int K_UP    = 0;
    localparam int K_DOWN  = 1;
    localparam int K_FAULT = 2;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic sens_a = 1'b0;
    logic sens_b = 1'b0;
    logic up, down, fault, busy;

    int tests = 0;
    int fails = 0;

    door_sensor_decoder #(
        .DEBOUNCE_CYCLES(DB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .sens_a(sens_a),
        .sens_b(sens_b),
        .up    (up),
        .down  (down),
        .fault (fault),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    int  cyc = 0;

    // Reference model: patterns are {A,B}; a walk is a position along a doorway sequence.
    logic [1:0] seq_ent [0:4];
    logic [1:0] seq_ext [0:4];
    logic [1:0] m_s1   = '0;
    logic [1:0] m_s2   = '0;
    logic [1:0] m_filt = '0;
    bit         hist_a[$];
    bit         hist_b[$];
    int         m_dir   = 0;   // 0 idle, 1 entering, 2 exiting, 3 waiting for clear
    int         m_pos   = 0;
    int         m_dwell = 0;
    logic       m_busy  = 1'b0;

    int seen_up = 0, seen_down = 0, seen_fault = 0;
    int snap_up = 0, snap_down = 0, snap_fault = 0;

    task automatic check(input string name, input int got, input int expv);
        tests++;
        if (got != expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, expv, $time);
        end
    endtask

    function automatic bit all_diff(input bit q[$], input bit v);
        foreach (q[i]) if (q[i] == v) return 1'b0;
        return 1'b1;
    endfunction

    task automatic push_ev(input int kind);
        ev_t e;
        e.kind = kind;
        e.cyc  = cyc;
        exp_q.push_back(e);
    endtask

    task automatic model_fsm();
        int nd, np;
        logic [1:0] pat, nxt, prv, cur;
        nd  = m_dir;
        np  = m_pos;
        pat = m_filt;
        if ((m_dir == 1 || m_dir == 2) && m_dwell == int'(TO) - 1) begin
            nd = 3;
            push_ev(K_FAULT);
        end else if (m_dir == 0) begin
            if (pat == 2'b10) begin nd = 1; np = 1; end
            else if (pat == 2'b01) begin nd = 2; np = 1; end
            else if (pat == 2'b11) begin nd = 3; push_ev(K_FAULT); end
        end else if (m_dir == 3) begin
            if (pat == 2'b00) nd = 0;
        end else begin
            nxt = (m_dir == 1) ? seq_ent[m_pos + 1] : seq_ext[m_pos + 1];
            prv = (m_dir == 1) ? seq_ent[m_pos - 1] : seq_ext[m_pos - 1];
            cur = (m_dir == 1) ? seq_ent[m_pos]     : seq_ext[m_pos];
            if (pat == nxt) begin
                if (m_pos == 3) begin
                    nd = 0;
                    push_ev((m_dir == 1) ? K_UP : K_DOWN);
                end else begin
                    np = m_pos + 1;
                end
            end else if (pat == prv) begin
                if (m_pos == 1) nd = 0;
                else np = m_pos - 1;
            end else if (pat != cur) begin
                nd = 3;
                push_ev(K_FAULT);
            end
        end
        if (nd != m_dir || (np != m_pos && (nd == 1 || nd == 2)) || nd == 0 || nd == 3)
            m_dwell = 0;
        else
            m_dwell = m_dwell + 1;
        m_dir  = nd;
        m_pos  = np;
        m_busy = (m_dir != 0);
    endtask

    task automatic model_debounce();
        hist_a.push_back(m_s2[1]);
        hist_b.push_back(m_s2[0]);
        if (hist_a.size() > int'(DB)) void'(hist_a.pop_front());
        if (hist_b.size() > int'(DB)) void'(hist_b.pop_front());
        if (hist_a.size() == int'(DB) && all_diff(hist_a, m_filt[1])) m_filt[1] = ~m_filt[1];
        if (hist_b.size() == int'(DB) && all_diff(hist_b, m_filt[0])) m_filt[0] = ~m_filt[0];
    endtask

    // Model advances on every clock edge and clears immediately on reset.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            cyc++;
            if (rst) begin
                m_s1 = '0; m_s2 = '0; m_filt = '0;
                hist_a.delete(); hist_b.delete();
                m_dir = 0; m_pos = 0; m_dwell = 0; m_busy = 1'b0;
                exp_q.delete();
            end else begin
                model_fsm();
                model_debounce();
                m_s2 = m_s1;
                m_s1 = {sens_a, sens_b};
            end
        end
    end

    // Monitor: compare pulses against the scoreboard and busy against the model.
    initial begin
        int n, kind;
        ev_t e;
        forever begin
            @(negedge clk);
            n = int'(up) + int'(down) + int'(fault);
            check("one_hot_pulses", int'(n <= 1), 1);
            check("busy", int'(busy), int'(m_busy));
            if (n >= 1) begin
                kind = up ? K_UP : (down ? K_DOWN : K_FAULT);
                if (kind == K_UP) seen_up++;
                else if (kind == K_DOWN) seen_down++;
                else seen_fault++;
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse_kind", kind, -1);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind", kind, e.kind);
                    check("pulse_cycle", cyc, e.cyc);
                end
            end
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                check("missed_pulse_kind", -1, e.kind);
            end
        end
    end

    task automatic hold(input logic a, input logic b, input int n);
        sens_a = a;
        sens_b = b;
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic snap();
        snap_up    = seen_up;
        snap_down  = seen_down;
        snap_fault = seen_fault;
    endtask

    task automatic delta(input string name, input int eu, input int ed, input int ef);
        check({name, "_up"},    seen_up - snap_up, eu);
        check({name, "_down"},  seen_down - snap_down, ed);
        check({name, "_fault"}, seen_fault - snap_fault, ef);
    endtask

    initial begin
        int p, len;
        seq_ent[0] = 2'b00; seq_ent[1] = 2'b10; seq_ent[2] = 2'b11; seq_ent[3] = 2'b01; seq_ent[4] = 2'b00;
        seq_ext[0] = 2'b00; seq_ext[1] = 2'b01; seq_ext[2] = 2'b11; seq_ext[3] = 2'b10; seq_ext[4] = 2'b00;

        repeat (3) @(posedge clk);
        #2;
        check("rst_up", int'(up), 0);
        check("rst_down", int'(down), 0);
        check("rst_fault", int'(fault), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b0;
        hold(0, 0, 5);

        snap();
        hold(1, 0, 10); hold(1, 1, 10); hold(0, 1, 10); hold(0, 0, 10); hold(0, 0, 20);
        delta("entry", 1, 0, 0);

        snap();
        hold(0, 1, 10); hold(1, 1, 10); hold(1, 0, 10); hold(0, 0, 10); hold(0, 0, 20);
        delta("exit", 0, 1, 0);

        snap();
        for (int i = 0; i < 5; i++) begin
            hold(1, 0, 2);
            hold(0, 0, 2);
        end
        hold(0, 0, 20);
        delta("bounce", 0, 0, 0);

        snap();
        hold(1, 0, 10); hold(1, 1, 10); hold(1, 0, 10); hold(0, 0, 10); hold(0, 0, 20);
        delta("backout", 0, 0, 0);

        snap();
        hold(1, 0, 100);
        hold(0, 0, 20);
        delta("timeout", 0, 0, 1);

        snap();
        hold(1, 0, 10); hold(1, 1, 10); hold(0, 1, 10);
        check("ent3_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        check("midrst_up", int'(up), 0);
        check("midrst_down", int'(down), 0);
        check("midrst_fault", int'(fault), 0);
        check("midrst_busy", int'(busy), 0);
        sens_a = 1'b0;
        sens_b = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        hold(0, 0, 20);
        delta("midrst", 0, 0, 0);

        snap();
        rst = 1'b1;
        sens_a = 1'b1;
        sens_b = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        hold(1, 1, 20);
        hold(0, 0, 20);
        delta("broken_at_release", 0, 0, 1);

        for (int i = 0; i < 400; i++) begin
            p   = int'($urandom_range(0, 3));
            len = ($urandom_range(0, 19) == 0) ? 70 : int'($urandom_range(1, 12));
            hold(p[1], p[0], len);
        end
        hold(0, 0, 80);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
